fcl_pos_ramp: RTL and testbench

FCL_POS_RAMP -- requirements
Module: fcl_pos_ramp

---
 rtl/fcl_servo_pkg.sv | 39 +++
 rtl/fcl_pos_step.sv | 42 ++++
 rtl/fcl_pos_ramp.sv | 163 ++++++++++++++++
 tb/tb_fcl_pos_ramp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fcl_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcl_servo_pkg
// Description : Shared servo position width, step width, home position
//               default, ramp state encoding and the position clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fcl_servo_pkg;

    localparam int POS_W  = 10;
    localparam int STEP_W = 6;

    localparam logic [POS_W-1:0] HOME_POS_DEFAULT = 10'h200;

    typedef enum logic [1:0] {
        ST_SEED = 2'd0,
        ST_IDLE = 2'd1,
        ST_RAMP = 2'd2
    } ramp_state_t;

    // Saturate a one-bit-wider unsigned position into [lo, hi].
    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W:0]   value,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic [POS_W-1:0] result;
        if (value < {1'b0, lo}) begin
            result = lo;
        end else if (value > {1'b0, hi}) begin
            result = hi;
        end else begin
            result = value[POS_W-1:0];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fcl_pos_step.sv
`default_nettype none
// ============================================================================
// Module      : fcl_pos_step
// Description : One ramp step. Moves current toward target by at most step,
//               landing exactly on target when it is within reach. Result is
//               clamped to [POS_MIN, POS_MAX].
// Revision    : 1.0 - initial release
// ============================================================================
module fcl_pos_step
    import fcl_servo_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MIN = 10'h000,
    parameter logic [POS_W-1:0] POS_MAX = 10'h3FF
) (
    input  logic [POS_W-1:0]  current,
    input  logic [POS_W-1:0]  target,
    input  logic [STEP_W-1:0] step,
    output logic [POS_W-1:0]  next
);

    logic signed [POS_W:0] w_diff;
    logic        [POS_W:0] w_mag;
    logic        [POS_W:0] w_step_ext;
    logic        [POS_W:0] w_move;

    // Signed distance to target, then either snap to target or advance by step.
    always_comb begin
        w_diff     = $signed({1'b0, target}) - $signed({1'b0, current});
        w_mag      = w_diff[POS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        w_step_ext = {{(POS_W + 1 - STEP_W){1'b0}}, step};
        if (w_mag <= w_step_ext) begin
            w_move = {1'b0, target};
        end else if (w_diff[POS_W]) begin
            w_move = {1'b0, current} - w_step_ext;
        end else begin
            w_move = {1'b0, current} + w_step_ext;
        end
        next = clamp_pos(w_move, POS_MIN, POS_MAX);
    end

endmodule
`default_nettype wire

// File: rtl/fcl_pos_ramp.sv
`default_nettype none
// ============================================================================
// Module      : fcl_pos_ramp
// Description : Servo goal-position ramp. Seeds from measured feedback, then
//               slews the commanded position toward the latched target by at
//               most max_step_in per sync tick.
//               Optional feature macro: FCL_POS_RAMP_WDOG_EN (target-write
//               watchdog that returns the target to HOME_POS).
// Revision    : 1.0 - initial release
// ============================================================================
module fcl_pos_ramp
    import fcl_servo_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MIN    = 10'h000,
    parameter logic [POS_W-1:0] POS_MAX    = 10'h3FF,
    parameter logic [POS_W-1:0] HOME_POS   = HOME_POS_DEFAULT,
    parameter int               WDOG_TICKS = 800
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [POS_W-1:0]  target_pos_in,
    input  logic              target_we_in,
    input  logic [STEP_W-1:0] max_step_in,
    input  logic              sync_in,
    input  logic [POS_W-1:0]  fb_pos_in,
    input  logic              fb_valid_in,
    output logic [POS_W-1:0]  pos_out,
    output logic              pos_we_out,
    output logic              at_target_out,
    output logic              wdog_trip_out
);

    ramp_state_t      r_state;
    ramp_state_t      w_state_nxt;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_target;
    logic             r_pos_we;
    logic [POS_W-1:0] w_fb_clamped;
    logic [POS_W-1:0] w_wr_clamped;
    logic [POS_W-1:0] w_step_next;
    logic             w_seed_load;
    logic             w_step_en;
    logic             w_wdog_fire;

    assign w_fb_clamped = clamp_pos({1'b0, fb_pos_in}, POS_MIN, POS_MAX);
    assign w_wr_clamped = clamp_pos({1'b0, target_pos_in}, POS_MIN, POS_MAX);

    fcl_pos_step #(
        .POS_MIN (POS_MIN),
        .POS_MAX (POS_MAX)
    ) u_step (
        .current (r_pos),
        .target  (r_target),
        .step    (max_step_in),
        .next    (w_step_next)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_SEED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus seed-load and step-enable decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_seed_load = 1'b0;
        w_step_en   = 1'b0;
        case (r_state)
            ST_SEED: begin
                if (fb_valid_in) begin
                    w_seed_load = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (r_target != r_pos) begin
                    w_state_nxt = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // Target may have been rewritten back onto the current position.
                if (r_target == r_pos) begin
                    w_state_nxt = ST_IDLE;
                end else if (sync_in && (max_step_in != '0)) begin
                    w_step_en = 1'b1;
                    if (w_step_next == r_target) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEED;
            end
        endcase
    end

    // Position, target and update strobe; the seed overrides any target write.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_pos    <= HOME_POS;
            r_target <= HOME_POS;
            r_pos_we <= 1'b0;
        end else begin
            r_pos_we <= 1'b0;
            if (target_we_in) begin
                r_target <= w_wr_clamped;
            end else if (w_wdog_fire) begin
                r_target <= HOME_POS;
            end
            if (w_seed_load) begin
                r_pos    <= w_fb_clamped;
                r_target <= w_fb_clamped;
                r_pos_we <= 1'b1;
            end else if (w_step_en) begin
                r_pos    <= w_step_next;
                r_pos_we <= 1'b1;
            end
        end
    end

`ifdef FCL_POS_RAMP_WDOG_EN
    localparam int c_WDOG_W = $clog2(WDOG_TICKS + 1);

    logic [c_WDOG_W-1:0] r_wdog_cnt;
    logic                r_wdog_trip;

    // A target write in the same cycle restarts the count instead of firing.
    assign w_wdog_fire = sync_in && !target_we_in && !r_wdog_trip &&
                         (r_wdog_cnt == c_WDOG_W'(WDOG_TICKS - 1));

    // Count sync ticks since the last target write; trip is sticky until reset.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            if (target_we_in) begin
                r_wdog_cnt <= '0;
            end else if (sync_in && !r_wdog_trip) begin
                r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
            end
            if (w_wdog_fire) begin
                r_wdog_trip <= 1'b1;
            end
        end
    end

    assign wdog_trip_out = r_wdog_trip;
`else
    assign w_wdog_fire   = 1'b0;
    assign wdog_trip_out = 1'b0;
`endif

    assign pos_out       = r_pos;
    assign pos_we_out    = r_pos_we;
    assign at_target_out = (r_state != ST_SEED) && (r_pos == r_target);

endmodule
`default_nettype wire

// File: tb/tb_fcl_pos_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcl_pos_ramp
// Description : Directed self-checking bench for fcl_pos_ramp.
//               Watchdog checks follow FCL_POS_RAMP_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fcl_pos_ramp;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b1;
    logic [9:0] target_pos_in = '0;
    logic       target_we_in = 1'b0;
    logic [5:0] max_step_in = '0;
    logic       sync_in = 1'b0;
    logic [9:0] fb_pos_in = '0;
    logic       fb_valid_in = 1'b0;
    logic [9:0] pos_out;
    logic       pos_we_out;
    logic       at_target_out;
    logic       wdog_trip_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_bad    = 0;
    int we_cnt   = 0;
    int we_base  = 0;

    fcl_pos_ramp #(
        .WDOG_TICKS (4)
    ) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .target_pos_in (target_pos_in),
        .target_we_in  (target_we_in),
        .max_step_in   (max_step_in),
        .sync_in       (sync_in),
        .fb_pos_in     (fb_pos_in),
        .fb_valid_in   (fb_valid_in),
        .pos_out       (pos_out),
        .pos_we_out    (pos_we_out),
        .at_target_out (at_target_out),
        .wdog_trip_out (wdog_trip_out)
    );

    always #5 clk_in = ~clk_in;

    // Strobe counter sampled mid-cycle.
    always @(negedge clk_in) begin
        if (pos_we_out === 1'b1) we_cnt++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_in     = 1'b1;
        fb_valid_in  = 1'b0;
        sync_in      = 1'b0;
        target_we_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b0;
    endtask

    task automatic seed(input logic [9:0] v);
        fb_pos_in   = v;
        fb_valid_in = 1'b1;
        tick();
    endtask

    task automatic write_target(input logic [9:0] v);
        target_pos_in = v;
        target_we_in  = 1'b1;
        tick();
        target_we_in  = 1'b0;
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        tick();
        sync_in = 1'b0;
    endtask

    // Bounded ramp; keep=1 re-writes the same target before each tick.
    task automatic ramp_to(input logic [9:0] t, input bit keep);
        for (int i = 0; i < 40 && at_target_out !== 1'b1; i++) begin
            if (keep) write_target(t);
            pulse_sync();
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        reset_in = 1'b1;
        tick();
        chk("reset_pos", pos_out, 32'h200);
        chk("reset_we", pos_we_out, 0);
        chk("reset_at", at_target_out, 0);
        chk("reset_wdog", wdog_trip_out, 0);
        reset_in = 1'b0;
        we_base = we_cnt;

        // Seed wait: no feedback, a sync has no effect
        tick();
        pulse_sync();
        tick();
        chk("seed_wait_pos", pos_out, 32'h200);
        chk("seed_wait_at", at_target_out, 0);

        // Seed from feedback 0x150
        seed(10'h150);
        chk("seed_pos", pos_out, 32'h150);
        chk("seed_we", pos_we_out, 1);
        chk("seed_at", at_target_out, 1);
        tick();
        tick();
        chk("seed_we_low", pos_we_out, 0);
        chk("seed_strobes", we_cnt - we_base, 1);

        // Ramp 0x150 -> 0x180 by 8
        max_step_in = 6'd8;
        we_base = we_cnt;
        write_target(10'h180);
        tick();
        for (int i = 1; i <= 6; i++) begin
            write_target(10'h180);
            pulse_sync();
            chk("ramp8_pos", pos_out, 32'h150 + 32'd8 * i);
            chk("ramp8_we", pos_we_out, 1);
            if (i == 1) chk("ramp8_mid_at", at_target_out, 0);
        end
        tick();
        tick();
        chk("ramp8_done_at", at_target_out, 1);
        chk("ramp8_strobes", we_cnt - we_base, 6);

        // Coincident write and sync uses the old target
        write_target(10'h1C0);
        tick();
        pulse_sync();
        chk("coinc_pre", pos_out, 32'h188);
        target_pos_in = 10'h100;
        target_we_in  = 1'b1;
        sync_in       = 1'b1;
        tick();
        target_we_in  = 1'b0;
        sync_in       = 1'b0;
        chk("coinc_old_tgt", pos_out, 32'h190);
        chk("coinc_we", pos_we_out, 1);
        pulse_sync();
        chk("coinc_new_tgt", pos_out, 32'h188);
        max_step_in = 6'd63;
        ramp_to(10'h100, 1'b1);
        chk("coinc_final", pos_out, 32'h100);

        // Low boundary: 0x005 -> 0x000 in one step
        do_reset();
        seed(10'h005);
        chk("low_seed", pos_out, 32'h005);
        write_target(10'h000);
        tick();
        pulse_sync();
        chk("low_pos", pos_out, 32'h000);
        chk("low_we", pos_we_out, 1);
        tick();
        chk("low_we_low", pos_we_out, 0);
        chk("low_at", at_target_out, 1);

        // High boundary: 0x3F0 -> 0x3FF
        do_reset();
        seed(10'h3F0);
        write_target(10'h3FF);
        tick();
        pulse_sync();
        chk("high_pos", pos_out, 32'h3FF);

        // Zero step freezes motion
        max_step_in = 6'd0;
        write_target(10'h300);
        tick();
        we_base = we_cnt;
        for (int i = 0; i < 3; i++) pulse_sync();
        tick();
        chk("zero_pos", pos_out, 32'h3FF);
        chk("zero_strobes", we_cnt - we_base, 0);
        write_target(10'h300);
        max_step_in = 6'd63;
        pulse_sync();
        chk("resume_pos", pos_out, 32'h3C0);

        // Reset mid-ramp: no strobe, home position
        reset_in = 1'b1;
        sync_in  = 1'b1;
        tick();
        sync_in  = 1'b0;
        chk("midrst_we", pos_we_out, 0);
        chk("midrst_pos", pos_out, 32'h200);
        chk("midrst_at", at_target_out, 0);
        reset_in = 1'b0;

`ifdef FCL_POS_RAMP_WDOG_EN
        // Watchdog: 4 ticks without a write sends target home
        do_reset();
        seed(10'h150);
        tick();
        for (int i = 0; i < 3; i++) pulse_sync();
        chk("wdog_pre", wdog_trip_out, 0);
        pulse_sync();
        chk("wdog_trip", wdog_trip_out, 1);
        tick();
        ramp_to(10'h200, 1'b0);
        chk("wdog_home", pos_out, 32'h200);
        chk("wdog_sticky", wdog_trip_out, 1);
        do_reset();
        chk("wdog_clear", wdog_trip_out, 0);
`else
        // No watchdog: many idle ticks leave everything alone
        do_reset();
        seed(10'h150);
        tick();
        for (int i = 0; i < 6; i++) pulse_sync();
        chk("nowdog_trip", wdog_trip_out, 0);
        chk("nowdog_pos", pos_out, 32'h150);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
